// File: rtl/mem_rw_arbiter_if.sv
// Command/strobe bundle between the two DDR burst requesters, the arbiter and the DDR controller.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_rw_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 30
);
   logic                  wr_ddr_req_i;
   logic [7:0]            wr_ddr_len_i;
   logic [ADDR_WIDTH-1:0] wr_ddr_addr_i;
   logic                  wr_ddr_data_req_o;
   logic                  wr_ddr_finish_o;
   logic                  rd_ddr_req_i;
   logic [7:0]            rd_ddr_len_i;
   logic [ADDR_WIDTH-1:0] rd_ddr_addr_i;
   logic                  rd_ddr_data_valid_o;
   logic                  rd_ddr_finish_o;
   logic                  mem_req_o;
   logic                  mem_wr_o;
   logic [7:0]            mem_len_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_wr_data_req_i;
   logic                  mem_rd_data_valid_i;
   logic                  mem_finish_i;
   logic                  timeout_err_o;

   modport slave (
      input  wr_ddr_req_i, wr_ddr_len_i, wr_ddr_addr_i,
      input  rd_ddr_req_i, rd_ddr_len_i, rd_ddr_addr_i,
      input  mem_wr_data_req_i, mem_rd_data_valid_i, mem_finish_i,
      output wr_ddr_data_req_o, wr_ddr_finish_o,
      output rd_ddr_data_valid_o, rd_ddr_finish_o,
      output mem_req_o, mem_wr_o, mem_len_o, mem_addr_o, timeout_err_o
   );

   modport master (
      output wr_ddr_req_i, wr_ddr_len_i, wr_ddr_addr_i,
      output rd_ddr_req_i, rd_ddr_len_i, rd_ddr_addr_i,
      output mem_wr_data_req_i, mem_rd_data_valid_i, mem_finish_i,
      input  wr_ddr_data_req_o, wr_ddr_finish_o,
      input  rd_ddr_data_valid_o, rd_ddr_finish_o,
      input  mem_req_o, mem_wr_o, mem_len_o, mem_addr_o, timeout_err_o
   );
endinterface

// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter sharing one DDR controller command port between a write and a read requester.
// Optional per-burst watchdog is enabled by defining ARB_WATCHDOG_EN.
module mem_rw_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 30,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic             ddr_clk_i,
   input  logic             ddr_rst_n_i,
   mem_rw_arbiter_if.slave  bus_io
);
   typedef enum logic [1:0] {StIdle, StWrBusy, StRdBusy, StGap} state_e;

   state_e                state_q, state_d;
   logic                  last_wr_q, last_wr_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_wr_q, mem_wr_d;
   logic [7:0]            mem_len_q, mem_len_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  wr_fin_q, wr_fin_d;
   logic                  rd_fin_q, rd_fin_d;
   logic                  busy, timeout, grant_wr, grant_rd;

   assign busy = (state_q == StWrBusy) || (state_q == StRdBusy);
   // Contested requests go to the side that did not win last time.
   assign grant_wr = bus_io.wr_ddr_req_i && (!bus_io.rd_ddr_req_i || !last_wr_q);
   assign grant_rd = bus_io.rd_ddr_req_i && !grant_wr;

`ifdef ARB_WATCHDOG_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_err_q, timeout_err_d;

   assign timeout       = busy && (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) && !bus_io.mem_finish_i;
   assign cnt_d         = busy ? cnt_q + CntW'(1) : '0;
   assign timeout_err_d = timeout_err_q | timeout;

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus_io.timeout_err_o = timeout_err_q;
`else
   assign timeout              = 1'b0;
   assign bus_io.timeout_err_o = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      last_wr_d  = last_wr_q;
      mem_req_d  = mem_req_q;
      mem_wr_d   = mem_wr_q;
      mem_len_d  = mem_len_q;
      mem_addr_d = mem_addr_q;
      wr_fin_d   = 1'b0;
      rd_fin_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_wr) begin
               state_d    = StWrBusy;
               last_wr_d  = 1'b1;
               mem_req_d  = 1'b1;
               mem_wr_d   = 1'b1;
               mem_len_d  = bus_io.wr_ddr_len_i;
               mem_addr_d = bus_io.wr_ddr_addr_i;
            end else if (grant_rd) begin
               state_d    = StRdBusy;
               last_wr_d  = 1'b0;
               mem_req_d  = 1'b1;
               mem_wr_d   = 1'b0;
               mem_len_d  = bus_io.rd_ddr_len_i;
               mem_addr_d = bus_io.rd_ddr_addr_i;
            end
         end
         StWrBusy, StRdBusy: begin
            // Controller has accepted the command once it starts moving data or completes.
            if (bus_io.mem_wr_data_req_i || bus_io.mem_rd_data_valid_i || bus_io.mem_finish_i) begin
               mem_req_d = 1'b0;
            end
            if (bus_io.mem_finish_i || timeout) begin
               state_d   = StGap;
               mem_req_d = 1'b0;
               wr_fin_d  = (state_q == StWrBusy);
               rd_fin_d  = (state_q == StRdBusy);
            end
         end
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
      if (!ddr_rst_n_i) begin
         state_q    <= StIdle;
         last_wr_q  <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_len_q  <= '0;
         mem_addr_q <= '0;
         wr_fin_q   <= 1'b0;
         rd_fin_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_wr_q  <= last_wr_d;
         mem_req_q  <= mem_req_d;
         mem_wr_q   <= mem_wr_d;
         mem_len_q  <= mem_len_d;
         mem_addr_q <= mem_addr_d;
         wr_fin_q   <= wr_fin_d;
         rd_fin_q   <= rd_fin_d;
      end
   end

   assign bus_io.wr_ddr_data_req_o   = bus_io.mem_wr_data_req_i && (state_q == StWrBusy);
   assign bus_io.rd_ddr_data_valid_o = bus_io.mem_rd_data_valid_i && (state_q == StRdBusy);
   assign bus_io.wr_ddr_finish_o     = wr_fin_q;
   assign bus_io.rd_ddr_finish_o     = rd_fin_q;
   assign bus_io.mem_req_o           = mem_req_q;
   assign bus_io.mem_wr_o            = mem_wr_q;
   assign bus_io.mem_len_o           = mem_len_q;
   assign bus_io.mem_addr_o          = mem_addr_q;
endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Directed plus randomized bench for mem_rw_arbiter against a grant/burst reference model.
// Honours ARB_WATCHDOG_EN to select the watchdog expectations.
module tb_mem_rw_arbiter;
   localparam int unsigned AW = 30;
`ifdef ARB_WATCHDOG_EN
   localparam int LongWait = 8;
   localparam int BigBeats = 10;
`else
   localparam int LongWait = 140;
   localparam int BigBeats = 128;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   bit   m_last_wr = 1'b0;  // model: 1 when the last grant went to write

   mem_rw_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   mem_rw_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
      .ddr_clk_i  (clk),
      .ddr_rst_n_i(rst_n),
      .bus_io     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_grant_wr(input bit wr, input bit rd);
      if (wr && !rd) return 1'b1;
      if (rd && !wr) return 1'b0;
      return !m_last_wr;
   endfunction

   task automatic clr_strobes();
      bus.mem_wr_data_req_i   = 1'b0;
      bus.mem_rd_data_valid_i = 1'b0;
      bus.mem_finish_i        = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, bus.mem_req_o, 0);
      chk({tag, "_dir"}, bus.mem_wr_o, 0);
      chk({tag, "_len"}, bus.mem_len_o, 0);
      chk({tag, "_addr"}, bus.mem_addr_o, 0);
      chk({tag, "_wfin"}, bus.wr_ddr_finish_o, 0);
      chk({tag, "_rfin"}, bus.rd_ddr_finish_o, 0);
      chk({tag, "_wdat"}, bus.wr_ddr_data_req_o, 0);
      chk({tag, "_rdat"}, bus.rd_ddr_data_valid_o, 0);
      chk({tag, "_terr"}, bus.timeout_err_o, 0);
   endtask

   // Grants a burst from IDLE and checks the latched command; returns the expected direction.
   task automatic grant(input bit wr, input bit rd, input logic [7:0] wl, input logic [AW-1:0] wa,
                        input logic [7:0] rl, input logic [AW-1:0] ra, output bit exp_wr);
      bus.wr_ddr_req_i  = wr;
      bus.rd_ddr_req_i  = rd;
      bus.wr_ddr_len_i  = wl;
      bus.wr_ddr_addr_i = wa;
      bus.rd_ddr_len_i  = rl;
      bus.rd_ddr_addr_i = ra;
      exp_wr    = model_grant_wr(wr, rd);
      m_last_wr = exp_wr;
      tick();
      chk("grant_req", bus.mem_req_o, 1);
      chk("grant_dir", bus.mem_wr_o, exp_wr);
      chk("grant_len", bus.mem_len_o, exp_wr ? wl : rl);
      chk("grant_addr", bus.mem_addr_o, exp_wr ? wa : ra);
   endtask

   task automatic run_burst(input bit wr, input bit rd, input logic [7:0] wl, input logic [AW-1:0] wa,
                            input logic [7:0] rl, input logic [AW-1:0] ra, input int beats,
                            input int pre, input int fin_wait, input bit drop_req, input bit inject);
      bit exp_wr;
      int seen = 0;
      grant(wr, rd, wl, wa, rl, ra, exp_wr);
      if (drop_req) begin
         bus.wr_ddr_req_i = 1'b0;
         bus.rd_ddr_req_i = 1'b0;
      end
      repeat (pre) tick();
      chk("req_hold", bus.mem_req_o, 1);
      for (int b = 0; b < beats; b++) begin
         bus.mem_wr_data_req_i   = exp_wr | inject;
         bus.mem_rd_data_valid_i = !exp_wr | inject;
         #1;
         chk("gate_wr", bus.wr_ddr_data_req_o, exp_wr);
         chk("gate_rd", bus.rd_ddr_data_valid_o, !exp_wr);
         if (exp_wr ? bus.wr_ddr_data_req_o : bus.rd_ddr_data_valid_o) seen++;
         tick();
         if (b == 0) chk("req_drop", bus.mem_req_o, 0);
      end
      clr_strobes();
      repeat (fin_wait) tick();
      bus.mem_finish_i = 1'b1;
      tick();
      bus.mem_finish_i = 1'b0;
      chk("fin_wr", bus.wr_ddr_finish_o, exp_wr);
      chk("fin_rd", bus.rd_ddr_finish_o, !exp_wr);
      chk("fin_req", bus.mem_req_o, 0);
      // Strobes and finish in GAP and the following IDLE cycle must be ignored.
      bus.mem_wr_data_req_i   = 1'b1;
      bus.mem_rd_data_valid_i = 1'b1;
      bus.mem_finish_i        = 1'b1;
      #1;
      chk("gap_wdat", bus.wr_ddr_data_req_o, 0);
      chk("gap_rdat", bus.rd_ddr_data_valid_o, 0);
      tick();
      chk("idle_wfin", bus.wr_ddr_finish_o, 0);
      chk("idle_rfin", bus.rd_ddr_finish_o, 0);
      chk("idle_wdat", bus.wr_ddr_data_req_o, 0);
      chk("idle_rdat", bus.rd_ddr_data_valid_o, 0);
      clr_strobes();
      chk("beats", seen, beats);
   endtask

   initial begin
      bit exp_wr;
      bus.wr_ddr_req_i = 1'b0;
      bus.rd_ddr_req_i = 1'b0;
      bus.wr_ddr_len_i = '0;
      bus.rd_ddr_len_i = '0;
      bus.wr_ddr_addr_i = '0;
      bus.rd_ddr_addr_i = '0;
      clr_strobes();
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      m_last_wr = 1'b0;
      tick();
      chk_all_zero("idle");

      // Both requesters held from reset: alternation starting with write.
      for (int i = 0; i < 4; i++) begin
         run_burst(1, 1, 8'(16 + i), AW'(32'h1000 + i), 8'(64 + i), AW'(32'h2000 + i),
                   2, 1, 1, 0, 0);
      end
      bus.wr_ddr_req_i = 1'b0;
      bus.rd_ddr_req_i = 1'b0;

      // Long write burst to 0x400.
      run_burst(1, 0, 8'd128, AW'(32'h400), 8'd0, '0, 4, 0, LongWait, 1, 0);
      // Read burst with stray write pulls present on every beat.
      run_burst(0, 1, 8'd0, '0, 8'd128, AW'(32'h800), BigBeats, 0, 0, 1, 1);

      // Randomized traffic.
      for (int i = 0; i < 16; i++) begin
         bit wr, rd;
         wr = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         if (!wr && !rd) rd = 1'b1;
         run_burst(wr, rd, 8'($urandom), AW'($urandom), 8'($urandom), AW'($urandom),
                   $urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a read burst.
      grant(0, 1, 8'd0, '0, 8'd99, AW'(32'h3333), exp_wr);
      bus.rd_ddr_req_i        = 1'b0;
      bus.mem_rd_data_valid_i = 1'b1;
      bus.mem_wr_data_req_i   = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      clr_strobes();
      tick();
      rst_n = 1'b1;
      m_last_wr = 1'b0;
      tick();
      chk("rst_no_rfin", bus.rd_ddr_finish_o, 0);
      tick();
      chk("rst_no_rfin2", bus.rd_ddr_finish_o, 0);
      run_burst(1, 1, 8'd7, AW'(32'h44), 8'd9, AW'(32'h55), 1, 0, 0, 1, 0);

      // Withheld finish: watchdog fires after 16 busy cycles, or the burst just stays busy.
      grant(1, 0, 8'd5, AW'(32'h66), 8'd0, '0, exp_wr);
      bus.wr_ddr_req_i = 1'b0;
`ifdef ARB_WATCHDOG_EN
      repeat (15) tick();
      chk("wd_pre_fin", bus.wr_ddr_finish_o, 0);
      chk("wd_pre_err", bus.timeout_err_o, 0);
      tick();
      chk("wd_fin", bus.wr_ddr_finish_o, 1);
      chk("wd_err", bus.timeout_err_o, 1);
      chk("wd_req", bus.mem_req_o, 0);
      tick();
      chk("wd_fin_once", bus.wr_ddr_finish_o, 0);
      chk("wd_err_held", bus.timeout_err_o, 1);
`else
      repeat (40) tick();
      chk("nowd_fin", bus.wr_ddr_finish_o, 0);
      chk("nowd_err", bus.timeout_err_o, 0);
      chk("nowd_req", bus.mem_req_o, 1);
      bus.mem_wr_data_req_i = 1'b1;
      #1;
      chk("nowd_busy", bus.wr_ddr_data_req_o, 1);
      tick();
      clr_strobes();
      bus.mem_finish_i = 1'b1;
      tick();
      bus.mem_finish_i = 1'b0;
      chk("nowd_fin_late", bus.wr_ddr_finish_o, 1);
      tick();
`endif
      rst_n = 1'b0;
      #1;
      chk("final_err", bus.timeout_err_o, 0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
